// File: rtl/act_transfer.sv
// Layer-to-layer activation mover: scans the destination volume (optionally zero-bordered)
// one element per cycle, reading the producer over a fixed latency and writing the consumer.
module act_transfer #(
   parameter           NAME         = "ACT_TRANSFER_DEFAULT_NAME",
   parameter int       NUM_ENTRIES  = 16,
   parameter int       SRC_DIM      = 13,
   parameter int       PAD          = 0,
   parameter int       DST_DIM      = SRC_DIM + 2*PAD,
   parameter int       DATA_SIZE    = 64,
   parameter int       READ_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 src_valid,
   output logic [15:0]          src_read_index_entry,
   output logic [15:0]          src_read_index_y,
   output logic [15:0]          src_read_index_x,
   input  logic [DATA_SIZE-1:0] src_read_data,
   output logic                 dst_want_write,
   output logic [DATA_SIZE-1:0] dst_write_data,
   output logic [15:0]          dst_write_index_entry,
   output logic [15:0]          dst_write_index_y,
   output logic [15:0]          dst_write_index_x,
   output logic                 busy,
   output logic                 done
);

   localparam int          NAME_BITS = $bits(NAME);
   localparam logic [15:0] SRC16     = 16'(SRC_DIM);
   localparam logic [15:0] PAD16     = 16'(PAD);
   localparam logic [15:0] DLAST16   = 16'(DST_DIM - 1);
   localparam logic [15:0] ELAST16   = 16'(NUM_ENTRIES - 1);

   if (READ_LATENCY < 1 || READ_LATENCY > 4 || DST_DIM != SRC_DIM + 2*PAD || NAME_BITS == 0)
   begin : g_bad_params
      $error("act_transfer: inconsistent parameters");
   end

   typedef enum logic [2:0] {S_IDLE, S_WAIT_SRC, S_RUN, S_DRAIN, S_DONE} state_e;

   typedef struct packed {
      logic        valid;
      logic        is_real;
      logic [15:0] e;
      logic [15:0] y;
      logic [15:0] x;
   } slot_t;

   state_e      state_q;
   logic [15:0] e_q, y_q, x_q;
   logic [15:0] e_d, y_d, x_d;
   logic [15:0] src_e_q, src_y_q, src_x_q;
   logic        busy_q, done_q;
   slot_t       pipe_q [0:READ_LATENCY];

   logic [15:0] pos_e, pos_y, pos_x, dy, dx;
   logic        interior, last, launch, issue, in_flight;

   // Launching issues position (0,0,0) on the same edge, so RUN's first cycle already shows it.
   always_comb begin
      pos_e = '0;
      pos_y = '0;
      pos_x = '0;
      if (state_q == S_RUN) begin
         pos_e = e_q;
         pos_y = y_q;
         pos_x = x_q;
      end
      dy       = pos_y - PAD16;
      dx       = pos_x - PAD16;
      interior = (dy < SRC16) && (dx < SRC16);
      last     = (pos_e == ELAST16) && (pos_y == DLAST16) && (pos_x == DLAST16);
      x_d = pos_x + 16'd1;
      y_d = pos_y;
      e_d = pos_e;
      if (pos_x == DLAST16) begin
         x_d = '0;
         y_d = pos_y + 16'd1;
         if (pos_y == DLAST16) begin
            y_d = '0;
            e_d = (pos_e == ELAST16) ? '0 : pos_e + 16'd1;
         end
      end
      launch    = start && src_valid && (state_q inside {S_IDLE, S_WAIT_SRC, S_DONE});
      issue     = launch || (state_q == S_RUN);
      in_flight = 1'b0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) in_flight |= pipe_q[i].valid;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         e_q     <= '0;
         y_q     <= '0;
         x_q     <= '0;
         src_e_q <= '0;
         src_y_q <= '0;
         src_x_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pipe_q  <= '{default: '0};
      end else begin
         for (int unsigned i = 1; i <= READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
         pipe_q[0] <= '0;
         if (issue) begin
            pipe_q[0] <= '{valid: 1'b1, is_real: interior, e: pos_e, y: pos_y, x: pos_x};
            if (interior) begin
               src_e_q <= pos_e;
               src_y_q <= dy;
               src_x_q <= dx;
            end
            e_q     <= e_d;
            y_q     <= y_d;
            x_q     <= x_d;
            state_q <= last ? S_DRAIN : S_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  e_q <= '0;
                  y_q <= '0;
                  x_q <= '0;
                  if (start) state_q <= S_WAIT_SRC;
               end
               S_WAIT_SRC: if (!start) state_q <= S_IDLE;
               S_DRAIN: begin
                  if (!in_flight) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               S_DONE: begin
                  if (start) begin
                     state_q <= S_WAIT_SRC;
                     done_q  <= 1'b0;
                     e_q     <= '0;
                     y_q     <= '0;
                     x_q     <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign src_read_index_entry  = src_e_q;
   assign src_read_index_y      = src_y_q;
   assign src_read_index_x      = src_x_q;
   assign dst_want_write        = pipe_q[READ_LATENCY].valid;
   assign dst_write_index_entry = pipe_q[READ_LATENCY].e;
   assign dst_write_index_y     = pipe_q[READ_LATENCY].y;
   assign dst_write_index_x     = pipe_q[READ_LATENCY].x;
   assign dst_write_data        = (pipe_q[READ_LATENCY].valid && pipe_q[READ_LATENCY].is_real)
                                  ? src_read_data : '0;
   assign busy                  = busy_q;
   assign done                  = done_q;

endmodule

// File: tb/tb_act_transfer.sv
// Bench for act_transfer: three instances (copy L=1, copy L=3, padded) checked every cycle
// against a timing/volume model derived from the transfer rules.
module tb_act_transfer;

   localparam int P_NE [3] = '{2, 2, 1};
   localparam int P_SD [3] = '{3, 3, 2};
   localparam int P_PD [3] = '{0, 0, 1};
   localparam int P_L  [3] = '{1, 3, 1};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_s [3];
   logic        srcv    [3];
   logic [15:0] sre [3], sry [3], srx [3];
   logic [15:0] dwe [3], dwy [3], dwx [3];
   logic [63:0] rdata [3], wdata [3];
   logic        want [3], busy [3], done [3];
   logic [63:0] rd_s [3][3];

   int          n_cmp = 0;
   int          n_err = 0;
   longint      cyc = 0;
   longint      t_run [3];
   bit          fresh [3];
   bit          active [3];
   int          wcount [3];

   always #5 clk = ~clk;

   act_transfer #(.NAME("COPY_L1"), .NUM_ENTRIES(2), .SRC_DIM(3), .PAD(0), .DATA_SIZE(64),
                  .READ_LATENCY(1)) u_copy (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .src_valid(srcv[0]),
      .src_read_index_entry(sre[0]), .src_read_index_y(sry[0]), .src_read_index_x(srx[0]),
      .src_read_data(rdata[0]), .dst_want_write(want[0]), .dst_write_data(wdata[0]),
      .dst_write_index_entry(dwe[0]), .dst_write_index_y(dwy[0]), .dst_write_index_x(dwx[0]),
      .busy(busy[0]), .done(done[0]));

   act_transfer #(.NAME("COPY_L3"), .NUM_ENTRIES(2), .SRC_DIM(3), .PAD(0), .DATA_SIZE(64),
                  .READ_LATENCY(3)) u_lat (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .src_valid(srcv[1]),
      .src_read_index_entry(sre[1]), .src_read_index_y(sry[1]), .src_read_index_x(srx[1]),
      .src_read_data(rdata[1]), .dst_want_write(want[1]), .dst_write_data(wdata[1]),
      .dst_write_index_entry(dwe[1]), .dst_write_index_y(dwy[1]), .dst_write_index_x(dwx[1]),
      .busy(busy[1]), .done(done[1]));

   act_transfer #(.NAME("PAD1"), .NUM_ENTRIES(1), .SRC_DIM(2), .PAD(1), .DATA_SIZE(64),
                  .READ_LATENCY(1)) u_pad (
      .clk(clk), .rst_n(rst_n), .start(start_s[2]), .src_valid(srcv[2]),
      .src_read_index_entry(sre[2]), .src_read_index_y(sry[2]), .src_read_index_x(srx[2]),
      .src_read_data(rdata[2]), .dst_want_write(want[2]), .dst_write_data(wdata[2]),
      .dst_write_index_entry(dwe[2]), .dst_write_index_y(dwy[2]), .dst_write_index_x(dwx[2]),
      .busy(busy[2]), .done(done[2]));

   function automatic int dd(int d);
      return P_SD[d] + 2*P_PD[d];
   endfunction

   function automatic int nn(int d);
      return P_NE[d] * dd(d) * dd(d);
   endfunction

   function automatic logic [63:0] src_val(int d, int e, int y, int x);
      if (d == 2) return $realtobits(5.0);
      return $realtobits(real'(e*100 + y*10 + x));
   endfunction

   function automatic bit is_interior(int d, int y, int x);
      return y >= P_PD[d] && y < P_PD[d] + P_SD[d] && x >= P_PD[d] && x < P_PD[d] + P_SD[d];
   endfunction

   // Expected data for the j-th destination element in raster order (entry, y, x).
   function automatic logic [63:0] exp_data(int d, int j);
      int e, y, x;
      e = j / (dd(d)*dd(d));
      y = (j / dd(d)) % dd(d);
      x = j % dd(d);
      if (is_interior(d, y, x)) return src_val(d, e, y - P_PD[d], x - P_PD[d]);
      return 64'h0;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   // Producer memories with registered reads of the instance's latency.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         rd_s[d][0] <= src_val(d, int'(sre[d]), int'(sry[d]), int'(srx[d]));
         rd_s[d][1] <= rd_s[d][0];
         rd_s[d][2] <= rd_s[d][1];
      end
   end
   assign rdata[0] = rd_s[0][0];
   assign rdata[1] = rd_s[1][2];
   assign rdata[2] = rd_s[2][0];

   // Transfer model: a launch is accepted when idle or done; T is the first RUN cycle.
   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int d = 0; d < 3; d++) begin
         if (!rst_n) begin
            fresh[d]  = 1'b1;
            active[d] = 1'b0;
            wcount[d] = 0;
         end else if (start_s[d] && srcv[d] &&
                      (!active[d] || (cyc - 1) - t_run[d] >= longint'(P_L[d] + nn(d)))) begin
            active[d] = 1'b1;
            fresh[d]  = 1'b0;
            t_run[d]  = cyc;
            wcount[d] = 0;
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         longint k;
         int     n, l, j, e, y, x, w;
         bit     eb, ew, edn;
         n   = nn(d);
         l   = P_L[d];
         w   = dd(d);
         k   = cyc - t_run[d];
         eb  = active[d] && k <= longint'(l + n - 1);
         ew  = active[d] && k >= longint'(l) && k <= longint'(l + n - 1);
         edn = active[d] && k >= longint'(l + n);
         if (want[d]) wcount[d]++;
         chk($sformatf("busy[%0d]", d), 64'(busy[d]), 64'(eb));
         chk($sformatf("done[%0d]", d), 64'(done[d]), 64'(edn));
         chk($sformatf("want[%0d]", d), 64'(want[d]), 64'(ew));
         chk($sformatf("busy_and_done[%0d]", d), 64'(busy[d] & done[d]), 64'h0);
         if (ew) begin
            j = int'(k) - l;
            e = j / (w*w);
            y = (j / w) % w;
            x = j % w;
            chk($sformatf("dst_e[%0d] j=%0d", d, j), 64'(dwe[d]), 64'(e));
            chk($sformatf("dst_y[%0d] j=%0d", d, j), 64'(dwy[d]), 64'(y));
            chk($sformatf("dst_x[%0d] j=%0d", d, j), 64'(dwx[d]), 64'(x));
            chk($sformatf("dst_data[%0d] j=%0d", d, j), wdata[d], exp_data(d, j));
         end
         if (active[d] && k < longint'(n)) begin
            j = int'(k);
            e = j / (w*w);
            y = (j / w) % w;
            x = j % w;
            if (is_interior(d, y, x)) begin
               chk($sformatf("src_e[%0d] j=%0d", d, j), 64'(sre[d]), 64'(e));
               chk($sformatf("src_y[%0d] j=%0d", d, j), 64'(sry[d]), 64'(y - P_PD[d]));
               chk($sformatf("src_x[%0d] j=%0d", d, j), 64'(srx[d]), 64'(x - P_PD[d]));
            end
         end
         if (active[d] && k == longint'(l + n))
            chk($sformatf("write_count[%0d]", d), 64'(wcount[d]), 64'(n));
         if (fresh[d]) begin
            chk($sformatf("idle_src_idx[%0d]", d), {16'h0, sre[d], sry[d], srx[d]}, 64'h0);
            chk($sformatf("idle_dst_idx[%0d]", d), {16'h0, dwe[d], dwy[d], dwx[d]}, 64'h0);
            chk($sformatf("idle_dst_data[%0d]", d), wdata[d], 64'h0);
         end
      end
   end

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         start_s[d] = 1'b0;
         srcv[d]    = 1'b0;
      end
      chk("pin_copy_j17", exp_data(0, 17), 64'h405E_8000_0000_0000);
      chk("pin_lat_j4",   exp_data(1, 4),  64'h4026_0000_0000_0000);
      chk("pin_pad_j5",   exp_data(2, 5),  64'h4014_0000_0000_0000);
      chk("pin_pad_j7",   exp_data(2, 7),  64'h0);
      chk("pin_pad_j10",  exp_data(2, 10), 64'h4014_0000_0000_0000);
      chk("pin_pad_j15",  exp_data(2, 15), 64'h0);
      cycles(3);
      rst_n = 1'b1;
      cycles(1);

      // Handshake: wait for the source, abandon, then launch with the source already valid.
      start_s[0] = 1'b1;
      cycles(10);
      start_s[0] = 1'b0;
      cycles(1);
      srcv[0] = 1'b1;
      cycles(3);
      srcv[0]    = 1'b0;
      start_s[0] = 1'b1;
      cycles(2);
      srcv[0] = 1'b1;
      cycles(1);
      start_s[0] = 1'b0;
      srcv[0]    = 1'b0;
      cycles(25);

      // Reset after the fifth write, then a fresh full transfer.
      start_s[0] = 1'b1;
      srcv[0]    = 1'b1;
      cycles(6);
      rst_n      = 1'b0;
      start_s[0] = 1'b0;
      srcv[0]    = 1'b0;
      cycles(1);
      rst_n = 1'b1;
      cycles(2);

      // Start held through completion: a second transfer follows straight from DONE.
      start_s[0] = 1'b1;
      srcv[0]    = 1'b1;
      cycles(25);
      start_s[0] = 1'b0;
      srcv[0]    = 1'b0;
      cycles(25);

      start_s[1] = 1'b1;
      srcv[1]    = 1'b1;
      cycles(1);
      start_s[1] = 1'b0;
      srcv[1]    = 1'b0;
      cycles(26);

      start_s[2] = 1'b1;
      srcv[2]    = 1'b1;
      cycles(1);
      start_s[2] = 1'b0;
      srcv[2]    = 1'b0;
      cycles(22);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
